mc_ctrl_fsm: RTL and testbench

- Multi-cycle sequencing controller for the MIPS-32 core, complementing the single-cycle opcode decoder.
- Steps a shared-ALU/shared-memory datapath through fetch, decode, execute, memory and writeback states per instruction.
- Stalls on a memory ready handshake.
- Flags illegal opcodes and memory timeouts.

---
 rtl/mc_ctrl_fsm.sv | 214 +++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS-32 sequencing controller: walks a shared-ALU/shared-memory datapath
// through fetch/decode/execute/memory/writeback, with memory-ready stalls and timeout abort.
module mc_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       bus_err
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC     = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ADDI_EX  = 4'd11,
    S_ADDI_WB  = 4'd12
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_nxt;
  logic             r_illegal;
  logic             r_bus_err;
  logic             w_set_ill;
  logic             w_set_berr;
  logic             w_is_wait;
  logic             w_timeout;

  // Only the three memory-handshake states count wait cycles.
  assign w_is_wait = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_timeout = w_is_wait && !mem_ready && (r_wait_cnt == CNT_LAST);

  // State, wait counter and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_illegal  <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_nxt;
      r_illegal  <= r_illegal | w_set_ill;
      r_bus_err  <= r_bus_err | w_set_berr;
    end
  end

  // Next state and per-state datapath controls.
  always_comb begin
    w_next      = r_state;
    w_set_ill   = 1'b0;
    w_set_berr  = 1'b0;
    w_wait_nxt  = '0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;

    if (w_is_wait && !mem_ready && !w_timeout) begin
      w_wait_nxt = r_wait_cnt + CNT_W'(1);
    end

    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) begin
          w_next = S_DECODE;
        end else if (w_timeout) begin
          w_next     = S_IDLE;
          w_set_berr = 1'b1;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (op)
          OP_RTYPE:     w_next = S_EXEC;
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDI_EX;
          default: begin
            w_next     = S_FETCH;
            w_set_ill  = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) begin
          w_next = S_MEM_WB;
        end else if (w_timeout) begin
          w_next     = S_IDLE;
          w_set_berr = 1'b1;
        end
      end
      S_MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          w_next     = S_FETCH;
          instr_done = 1'b1;
        end else if (w_timeout) begin
          w_next     = S_IDLE;
          w_set_berr = 1'b1;
        end
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        w_next  = S_ALU_WB;
      end
      S_ALU_WB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign state      = r_state;
  assign illegal_op = r_illegal;
  assign bus_err    = r_bus_err;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed scenarios with literal expectations plus a randomized
// run checked every cycle against a path-based instruction model.
module tb_mc_ctrl_fsm;

  localparam int unsigned TO = 4;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic       instr_done, illegal_op, bus_err;

  int total = 0;
  int bad   = 0;

  mc_ctrl_fsm #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .instr_done(instr_done),
    .illegal_op(illegal_op), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}
  function automatic logic [15:0] dut_cv();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
            RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
  endfunction

  function automatic logic [15:0] exp_ctrl(input int st, input logic rdy);
    logic [15:0] v;
    v = '0;
    case (st)
      1:     begin v[12] = 1'b1; v[5:4] = 2'b01; v[15] = rdy; v[10] = rdy; end
      2:     v[5:4] = 2'b11;
      3, 11: begin v[6] = 1'b1; v[5:4] = 2'b10; end
      4:     begin v[12] = 1'b1; v[13] = 1'b1; end
      5:     begin v[7] = 1'b1; v[9] = 1'b1; end
      6:     begin v[11] = 1'b1; v[13] = 1'b1; end
      7:     begin v[6] = 1'b1; v[3:2] = 2'b10; end
      8:     begin v[7] = 1'b1; v[8] = 1'b1; end
      9:     begin v[6] = 1'b1; v[3:2] = 2'b01; v[14] = 1'b1; v[1:0] = 2'b01; end
      10:    begin v[15] = 1'b1; v[1:0] = 2'b10; end
      12:    v[7] = 1'b1;
      default: ;
    endcase
    return v;
  endfunction

  // Model: current state plus the queue of states still ahead in this instruction.
  int m_st = 0;
  int m_wait = 0;
  int m_ill = 0;
  int m_berr = 0;
  int m_q[$];

  function int take_next();
    if (m_q.size() > 0) return m_q.pop_front();
    return 1;
  endfunction

  always @(negedge clk) begin
    int  nxt;
    bit  legal;
    if (!rst_n) begin
      m_st = 0; m_wait = 0; m_ill = 0; m_berr = 0; m_q.delete();
    end
    legal = (op inside {6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8});
    chk("state", int'(state), m_st);
    chk("ctrl", int'(dut_cv()), int'(exp_ctrl(m_st, mem_ready)));
    chk("instr_done", int'(instr_done),
        int'((m_st inside {5, 8, 9, 10, 12}) || (m_st == 6 && mem_ready) || (m_st == 2 && !legal)));
    chk("illegal_op", int'(illegal_op), m_ill);
    chk("bus_err", int'(bus_err), m_berr);
    if (rst_n) begin
      nxt = m_st;
      case (m_st)
        0: nxt = 1;
        1, 4, 6: begin
          if (mem_ready) begin
            m_wait = 0;
            nxt = (m_st == 1) ? 2 : take_next();
          end else if (m_wait == int'(TO) - 1) begin
            m_wait = 0; m_berr = 1; m_q.delete(); nxt = 0;
          end else begin
            m_wait++;
          end
        end
        2: begin
          m_q.delete();
          case (op)
            6'd0:         begin m_q.push_back(7); m_q.push_back(8); end
            6'd35, 6'd43: m_q.push_back(3);
            6'd4:         m_q.push_back(9);
            6'd2:         m_q.push_back(10);
            6'd8:         begin m_q.push_back(11); m_q.push_back(12); end
            default:      m_ill = 1;
          endcase
          nxt = take_next();
        end
        3: begin
          m_q.delete();
          if (op == 6'd35) begin m_q.push_back(4); m_q.push_back(5); end
          else m_q.push_back(6);
          nxt = take_next();
        end
        default: nxt = take_next();
      endcase
      m_st = nxt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int s);
    int n;
    n = 0;
    while (int'(state) != s && n < 40) begin
      tick();
      n++;
    end
    chk("reach_state", int'(state), s);
  endtask

  logic [15:0] seen[16];

  // Runs one instruction from FETCH with mem_ready high; returns cycles until FETCH again.
  task automatic run_instr(input int o, output int cyc);
    op = 6'(o);
    mem_ready = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
      seen[state] = dut_cv();
    end while (state != 4'd1 && cyc < 20);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    int sq[6];
    int exp_seq[6];
    int rwmask, dn, c, thr;
    exp_seq = '{0, 1, 2, 7, 8, 1};

    rst_n = 1'b0; op = 6'd0; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_ctrl", int'(dut_cv()), 0);
    chk("rst_flags", int'({illegal_op, bus_err}), 0);

    tick();
    rst_n = 1'b1;
    rwmask = 0; dn = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sq[i] = int'(state);
      if (RegWrite || RegDst) rwmask |= (1 << state);
      dn += int'(instr_done);
    end
    for (int i = 0; i < 6; i++) chk("rtype_seq", sq[i], exp_seq[i]);
    chk("rtype_rw_states", rwmask, 1 << 8);
    chk("rtype_done_count", dn, 1);

    // lw with three stalled cycles in MEM_RD
    tick();
    op = 6'd35;
    wait_state(4);
    mem_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("lw_rd_hold", int'({state, MemRead, IorD}), (4 << 2) | 3);
      tick();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("lw_rd_last", int'({state, MemRead, IorD}), (4 << 2) | 3);
    tick();
    @(negedge clk);
    chk("lw_wb", int'({state, RegWrite, MemtoReg, instr_done}), (5 << 3) | 7);

    // sw with one stalled cycle
    tick();
    op = 6'd43;
    wait_state(6);
    mem_ready = 1'b0;
    @(negedge clk);
    chk("sw_wait", int'({MemWrite, instr_done, RegWrite}), 3'b100);
    tick();
    mem_ready = 1'b1;
    @(negedge clk);
    chk("sw_done", int'({MemWrite, instr_done, RegWrite}), 3'b110);
    tick();
    chk("sw_back", int'(state), 1);

    run_instr(4, c);  chk("beq_lat", c, 3);  chk("beq_ctrl", int'(seen[9]), 16'h4045);
    run_instr(2, c);  chk("j_lat", c, 3);    chk("j_ctrl", int'(seen[10]), 16'h8002);
    chk("fetch_ctrl", int'(seen[1]), 16'h9410);
    run_instr(0, c);  chk("rtype_lat", c, 4);
    run_instr(8, c);  chk("addi_lat", c, 4);
    chk("addi_ex_ctrl", int'(seen[11]), 16'h0060);
    chk("addi_wb_ctrl", int'(seen[12]), 16'h0080);
    run_instr(35, c); chk("lw_lat", c, 5);
    run_instr(43, c); chk("sw_lat", c, 4);
    run_instr(63, c); chk("illegal_lat", c, 2);
    chk("illegal_flag", int'(illegal_op), 1);
    run_instr(0, c);
    chk("illegal_sticky", int'(illegal_op), 1);

    // mem_ready arrives on the last allowed FETCH cycle
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    mem_ready = 1'b0;
    repeat (3) tick();
    chk("edge_fetch_hold", int'(state), 1);
    mem_ready = 1'b1;
    tick();
    chk("edge_decode", int'(state), 2);
    chk("edge_no_berr", int'(bus_err), 0);

    // FETCH timeout
    wait_state(1);
    mem_ready = 1'b0;
    repeat (3) tick();
    chk("to_hold", int'(state), 1);
    tick();
    chk("to_idle", int'(state), 0);
    chk("to_berr", int'(bus_err), 1);
    mem_ready = 1'b1;
    tick();

    // asynchronous reset during MEM_WR
    op = 6'd43;
    wait_state(6);
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_memwrite", int'(MemWrite), 0);
    chk("async_state", int'(state), 0);
    chk("async_berr", int'(bus_err), 0);
    tick();
    rst_n = 1'b1;
    mem_ready = 1'b1;

    for (int i = 0; i < 4000; i++) begin
      tick();
      rst_n = ($urandom_range(0, 499) != 0);
      case ($urandom_range(0, 7))
        0: op = 6'd0;
        1: op = 6'd35;
        2: op = 6'd43;
        3: op = 6'd4;
        4: op = 6'd2;
        5: op = 6'd8;
        6: op = 6'($urandom_range(0, 63));
        default: ;
      endcase
      thr = ((i / 64) % 2 == 1) ? 40 : 85;
      mem_ready = ($urandom_range(0, 99) < thr);
    end
    rst_n = 1'b1;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
